// File: rtl/bird_physics.sv
// Flappy-bird vertical physics and game-state controller; game steps come from
// a divided tick sampled as data, flaps from a raw button.
module bird_physics #(
  parameter int Y_START   = 240,
  parameter int Y_MAX     = 464,
  parameter int GRAVITY   = 1,
  parameter int FLAP_VEL  = -8,
  parameter int V_MAX     = 8,
  parameter int DEAD_HOLD = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_100,
  input  logic       btn_flap,
  input  logic       hit,
  output logic [9:0] bird_y,
  output logic [1:0] state,
  output logic       step
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] PLAY = 2'b01;
  localparam logic [1:0] DEAD = 2'b10;

  localparam logic        [9:0]  YST10  = 10'(Y_START);
  localparam logic        [9:0]  YMAX10 = 10'(Y_MAX);
  localparam logic signed [10:0] YMAX11 = 11'(Y_MAX);
  localparam logic signed [6:0]  GRAV7  = 7'(GRAVITY);
  localparam logic signed [6:0]  VMAX7  = 7'(V_MAX);
  localparam logic signed [5:0]  FLAP6  = 6'(FLAP_VEL);
  localparam logic        [5:0]  HOLD6  = 6'(DEAD_HOLD);

  logic [2:0]        s_q, b_q;
  logic [1:0]        state_q, state_d;
  logic [9:0]        y_q, y_d;
  logic signed [5:0] v_q, v_d;
  logic              pend_q, pend_d;
  logic [5:0]        dcnt_q, dcnt_d;
  logic              step_q;

  logic               step_int, flap_edge;
  logic signed [6:0]  v_inc;
  logic signed [5:0]  v_nxt;
  logic signed [10:0] y_sum;

  assign step_int  = s_q[1] & ~s_q[2];
  assign flap_edge = b_q[1] & ~b_q[2];

  // Velocity and position sums are widened so saturation and ceiling/floor
  // tests never see a wrapped value.
  always_comb begin
    v_inc = {v_q[5], v_q} + GRAV7;
    if (pend_q || flap_edge)
      v_nxt = FLAP6;
    else if (v_inc > VMAX7)
      v_nxt = VMAX7[5:0];
    else
      v_nxt = v_inc[5:0];
    y_sum = $signed({1'b0, y_q}) + {{5{v_nxt[5]}}, v_nxt};
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    v_d     = v_q;
    pend_d  = pend_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      IDLE: begin
        y_d    = YST10;
        v_d    = '0;
        dcnt_d = '0;
        if (flap_edge) begin
          state_d = PLAY;
          pend_d  = 1'b1;
        end
      end
      PLAY: begin
        if (hit) begin
          state_d = DEAD;
          pend_d  = 1'b0;
          dcnt_d  = '0;
        end else if (step_int) begin
          pend_d = 1'b0;
          if (y_sum[10]) begin
            y_d = '0;
            v_d = '0;
          end else if (y_sum >= YMAX11) begin
            y_d     = YMAX10;
            v_d     = '0;
            state_d = DEAD;
            dcnt_d  = '0;
          end else begin
            y_d = y_sum[9:0];
            v_d = v_nxt;
          end
        end else if (flap_edge) begin
          pend_d = 1'b1;
        end
      end
      DEAD: begin
        if (flap_edge && dcnt_q == HOLD6) begin
          state_d = IDLE;
          y_d     = YST10;
          v_d     = '0;
          dcnt_d  = '0;
          pend_d  = 1'b0;
        end else if (step_int && dcnt_q < HOLD6) begin
          dcnt_d = dcnt_q + 6'd1;
        end
      end
      default: begin
        state_d = IDLE;
        y_d     = YST10;
        v_d     = '0;
        pend_d  = 1'b0;
        dcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q     <= '0;
      b_q     <= '0;
      state_q <= IDLE;
      y_q     <= YST10;
      v_q     <= '0;
      pend_q  <= 1'b0;
      dcnt_q  <= '0;
      step_q  <= 1'b0;
    end else begin
      s_q     <= {s_q[1:0], clk_100};
      b_q     <= {b_q[1:0], btn_flap};
      state_q <= state_d;
      y_q     <= y_d;
      v_q     <= v_d;
      pend_q  <= pend_d;
      dcnt_q  <= dcnt_d;
      step_q  <= step_int;
    end
  end

  assign bird_y = y_q;
  assign state  = state_q;
  assign step   = step_q;

endmodule

// File: tb/tb_bird_physics.sv
// Directed bench for bird_physics: a game-level reference model checked every
// cycle, plus literal expectations pinning the model.
module tb_bird_physics;

  logic       clk = 1'b0;
  logic       rst, clk_100, btn_flap, hit;
  logic [9:0] bird_y;
  logic [1:0] state;
  logic       step;

  bird_physics #(
    .Y_START(240), .Y_MAX(464), .GRAVITY(1), .FLAP_VEL(-8), .V_MAX(8), .DEAD_HOLD(50)
  ) dut (
    .clk(clk), .rst(rst), .clk_100(clk_100), .btn_flap(btn_flap), .hit(hit),
    .bird_y(bird_y), .state(state), .step(step)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int stepcnt = 0;
  bit chk_en = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: input histories stand in for the synchronisers, the game
  // itself is plain integer arithmetic.
  int m_state, m_y, m_v, m_dc;
  bit m_pend, m_step;
  bit hc[1:3];
  bit hb[1:3];

  always @(posedge clk) begin
    int nv, ny;
    bit stp, fe;
    if (rst) begin
      m_state = 0; m_y = 240; m_v = 0; m_dc = 0; m_pend = 0; m_step = 0;
      for (int i = 1; i <= 3; i++) begin hc[i] = 0; hb[i] = 0; end
    end else begin
      stp = hc[2] && !hc[3];
      fe  = hb[2] && !hb[3];
      hc[3] = hc[2]; hc[2] = hc[1]; hc[1] = clk_100;
      hb[3] = hb[2]; hb[2] = hb[1]; hb[1] = btn_flap;
      m_step = stp;
      if (m_state == 0) begin
        m_y = 240; m_v = 0; m_dc = 0;
        if (fe) begin m_state = 1; m_pend = 1; end
      end else if (m_state == 1) begin
        if (hit) begin
          m_state = 2; m_dc = 0; m_pend = 0;
        end else if (stp) begin
          nv = (m_pend || fe) ? -8 : ((m_v + 1 > 8) ? 8 : m_v + 1);
          ny = m_y + nv;
          m_pend = 0;
          if (ny < 0) begin m_y = 0; m_v = 0; end
          else if (ny >= 464) begin m_y = 464; m_v = 0; m_state = 2; m_dc = 0; end
          else begin m_y = ny; m_v = nv; end
        end else if (fe) begin
          m_pend = 1;
        end
      end else begin
        if (fe && m_dc == 50) begin
          m_state = 0; m_y = 240; m_v = 0; m_dc = 0; m_pend = 0;
        end else if (stp && m_dc < 50) begin
          m_dc++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("state", int'(state), m_state);
      check("bird_y", int'(bird_y), m_y);
      check("step", int'(step), int'(m_step));
      if (step) stepcnt++;
    end
  end

  task automatic game_step();
    @(negedge clk) clk_100 = 1'b1;
    repeat (4) @(negedge clk);
    clk_100 = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic press();
    @(negedge clk) btn_flap = 1'b1;
    repeat (4) @(negedge clk);
    btn_flap = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    int c0;
    rst = 1'b1; clk_100 = 1'b0; btn_flap = 1'b0; hit = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    rst = 1'b0;
    check("rst_state", int'(state), 0);
    check("rst_y", int'(bird_y), 240);
    check("rst_step", int'(step), 0);

    // Start game and take two steps
    press();
    check("start_state", int'(state), 1);
    check("start_y", int'(bird_y), 240);
    c0 = stepcnt;
    game_step();
    check("step1_y", int'(bird_y), 232);
    game_step();
    check("step2_y", int'(bird_y), 225);
    check("two_pulses", stepcnt - c0, 2);

    // Flap every step until clamped at the ceiling
    for (int i = 0; i < 40; i++) begin
      press();
      game_step();
    end
    check("ceil_y", int'(bird_y), 0);
    check("ceil_state", int'(state), 1);

    // Free fall from rest at row 0: 1+2+..+8 then 8 per step
    repeat (12) game_step();
    check("fall12_y", int'(bird_y), 68);
    for (int i = 0; i < 100 && state != 2'b10; i++) game_step();
    check("floor_state", int'(state), 2);
    check("floor_y", int'(bird_y), 464);

    // Dead hold: flap after 49 steps ignored, after 50 restarts
    repeat (49) game_step();
    press();
    check("hold49_state", int'(state), 2);
    check("hold49_y", int'(bird_y), 464);
    game_step();
    press();
    check("restart_state", int'(state), 0);
    check("restart_y", int'(bird_y), 240);

    // Hit coincident with a step
    press();
    game_step();
    game_step();
    @(negedge clk) clk_100 = 1'b1;
    @(negedge clk);
    @(negedge clk) hit = 1'b1;
    @(negedge clk) hit = 1'b0;
    check("hitstep_state", int'(state), 2);
    check("hitstep_y", int'(bird_y), 225);
    check("hitstep_step", int'(step), 1);
    repeat (2) @(negedge clk);
    clk_100 = 1'b0;
    repeat (4) @(negedge clk);

    // Reset while dead, then hit ignored in IDLE
    do_reset();
    check("rstdead_state", int'(state), 0);
    @(negedge clk) hit = 1'b1;
    repeat (3) @(negedge clk);
    hit = 1'b0;
    check("idlehit_state", int'(state), 0);

    // Hit between steps freezes position
    press();
    game_step();
    @(negedge clk) hit = 1'b1;
    @(negedge clk) hit = 1'b0;
    check("hit_state", int'(state), 2);
    check("hit_y", int'(bird_y), 232);

    // Reset mid-play with a step pending; tick still high counts as a rise
    do_reset();
    press();
    game_step();
    @(negedge clk) clk_100 = 1'b1;
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check("rstplay_state", int'(state), 0);
    check("rstplay_y", int'(bird_y), 240);
    check("rstplay_step", int'(step), 0);
    c0 = stepcnt;
    repeat (5) @(negedge clk);
    clk_100 = 1'b0;
    check("first_high_pulse", stepcnt - c0, 1);
    repeat (4) @(negedge clk);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
